// File: rtl/axi4_lite_read_requester_pkg.sv
// Shared types for the AXI4-Lite read requester: response codes and FSM states.
package axi4_lite_read_requester_pkg;

    localparam int unsigned RESP_W  = 2;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [RESP_W-1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } read_req_state_t;

endpackage

// File: rtl/axi4_lite_read_requester_if.sv
// Command/response port plus AR/R channels of the read requester.
interface axi4_lite_read_requester_if
    import axi4_lite_read_requester_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned DATA_SIZE    = 32
);
    logic [ADDRESS_SIZE-1:0] cmd_address_i;
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic [DATA_SIZE-1:0]    rsp_data_o;
    logic [RESP_W-1:0]       rsp_response_o;
    logic                    rsp_timeout_o;
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [ADDRESS_SIZE-1:0] read_address_o;
    logic                    read_address_valid_o;
    logic                    read_address_ready_i;
    logic [DATA_SIZE-1:0]    read_data_i;
    logic [RESP_W-1:0]       read_data_response_i;
    logic                    read_data_valid_i;
    logic                    read_data_ready_o;

    modport master (
        input  cmd_address_i, cmd_valid_i, rsp_ready_i,
        input  read_address_ready_i, read_data_i, read_data_response_i, read_data_valid_i,
        output cmd_ready_o, rsp_data_o, rsp_response_o, rsp_timeout_o, rsp_valid_o,
        output read_address_o, read_address_valid_o, read_data_ready_o
    );

    modport slave (
        output cmd_address_i, cmd_valid_i, rsp_ready_i,
        output read_address_ready_i, read_data_i, read_data_response_i, read_data_valid_i,
        input  cmd_ready_o, rsp_data_o, rsp_response_o, rsp_timeout_o, rsp_valid_o,
        input  read_address_o, read_address_valid_o, read_data_ready_o
    );

endinterface

// File: rtl/axi4_lite_read_requester.sv
// Issues one AR+R transaction per local command and returns data/resp,
// with an R-phase timeout and discard of the late beat that follows it.
module axi4_lite_read_requester
    import axi4_lite_read_requester_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE   = 32,
    parameter int unsigned DATA_SIZE      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_clk_ni,
    axi4_lite_read_requester_if.master  bus,
    output logic                        busy_o
);

    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int unsigned CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    read_req_state_t         r_state, w_state_nxt;
    logic                    r_cmd_ready, w_cmd_ready_nxt;
    logic [ADDRESS_SIZE-1:0] r_ar_addr, w_ar_addr_nxt;
    logic                    r_ar_valid, w_ar_valid_nxt;
    logic                    r_r_ready, w_r_ready_nxt;
    logic [DATA_SIZE-1:0]    r_rsp_data, w_rsp_data_nxt;
    resp_t                   r_rsp_resp, w_rsp_resp_nxt;
    logic                    r_rsp_timeout, w_rsp_timeout_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_drain, w_drain_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;

    logic w_cmd_hs, w_ar_hs, w_r_hs, w_rsp_hs, w_expire;

    assign w_cmd_hs = bus.cmd_valid_i && r_cmd_ready;
    assign w_ar_hs  = r_ar_valid && bus.read_address_ready_i;
    assign w_r_hs   = bus.read_data_valid_i && r_r_ready;
    assign w_rsp_hs = r_rsp_valid && bus.rsp_ready_i;
    // Expiry on the last allowed DATA cycle; constant-false when the timeout is disabled.
    assign w_expire = TIMEOUT_EN && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_clk_ni) begin
        if (!rst_clk_ni) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_ar_addr     <= '0;
            r_ar_valid    <= 1'b0;
            r_r_ready     <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_resp    <= OKAY;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_drain       <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_ar_addr     <= w_ar_addr_nxt;
            r_ar_valid    <= w_ar_valid_nxt;
            r_r_ready     <= w_r_ready_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_resp    <= w_rsp_resp_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_drain       <= w_drain_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_cmd_hs)             w_state_nxt = ST_ADDR;
            ST_ADDR:  if (w_ar_hs)              w_state_nxt = ST_DATA;
            ST_DATA:  if (w_r_hs || w_expire)   w_state_nxt = ST_RESP;
            ST_RESP:  if (w_rsp_hs)             w_state_nxt = r_drain ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (w_r_hs)               w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the output registers
    always_comb begin
        w_cmd_ready_nxt   = r_cmd_ready;
        w_ar_addr_nxt     = r_ar_addr;
        w_ar_valid_nxt    = r_ar_valid;
        w_r_ready_nxt     = r_r_ready;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_resp_nxt    = r_rsp_resp;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_drain_nxt       = r_drain;
        w_cnt_nxt         = r_cnt;
        w_busy_nxt        = (w_state_nxt != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready_nxt = !w_cmd_hs;
                if (w_cmd_hs) begin
                    w_ar_addr_nxt  = bus.cmd_address_i;
                    w_ar_valid_nxt = 1'b1;
                end
            end
            ST_ADDR: begin
                if (w_ar_hs) begin
                    w_ar_valid_nxt = 1'b0;
                    w_r_ready_nxt  = 1'b1;
                    w_cnt_nxt      = '0;
                end
            end
            ST_DATA: begin
                // A beat in the expiry cycle takes priority over the timeout.
                if (w_r_hs) begin
                    w_rsp_data_nxt    = bus.read_data_i;
                    w_rsp_resp_nxt    = resp_t'(bus.read_data_response_i);
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_r_ready_nxt     = 1'b0;
                end else if (w_expire) begin
                    w_rsp_data_nxt    = '0;
                    w_rsp_resp_nxt    = SLVERR;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_valid_nxt   = 1'b1;
                    w_r_ready_nxt     = 1'b0;
                    w_drain_nxt       = 1'b1;
                end else if (TIMEOUT_EN) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (w_rsp_hs) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (r_drain) w_r_ready_nxt   = 1'b1;
                    else         w_cmd_ready_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_r_hs) begin
                    w_r_ready_nxt   = 1'b0;
                    w_drain_nxt     = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready_o          = r_cmd_ready;
    assign bus.read_address_o       = r_ar_addr;
    assign bus.read_address_valid_o = r_ar_valid;
    assign bus.read_data_ready_o    = r_r_ready;
    assign bus.rsp_data_o           = r_rsp_data;
    assign bus.rsp_response_o       = r_rsp_resp;
    assign bus.rsp_timeout_o        = r_rsp_timeout;
    assign bus.rsp_valid_o          = r_rsp_valid;
    assign busy_o                   = r_busy;

endmodule

// File: tb/tb_axi4_lite_read_requester.sv
// Bench for axi4_lite_read_requester: vector table of transactions against a
// configurable subordinate, scoreboard of expected responses, plus reset corners.
module tb_axi4_lite_read_requester;
    import axi4_lite_read_requester_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;
    localparam int unsigned NV = 10;

    typedef struct {
        logic [31:0] addr;
        int          ar_wait;
        int          r_wait;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        int          rsp_wait;
        int          exp_lat;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic        exp_to;
        bit          chk_tput;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        to;
    } exp_rsp_t;

    logic clk, rst_n, busy;
    axi4_lite_read_requester_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus();

    axi4_lite_read_requester #(
        .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_clk_ni(rst_n), .bus(bus), .busy_o(busy)
    );

    vec_t        vecs [NV];
    exp_rsp_t    sb [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          r_hs = 0;
    int          cfg_ar_wait = 0;
    int          cfg_r_wait = 0;
    logic [31:0] cfg_data = '0;
    logic [1:0]  cfg_resp = '0;
    bit          cfg_r_never = 0;
    logic [31:0] sub_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.read_data_valid_i && bus.read_data_ready_o) r_hs <= r_hs + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Subordinate: AR ready after cfg_ar_wait cycles, R beat cfg_r_wait cycles after AR.
    initial begin : sub
        bus.read_address_ready_i = 1'b0;
        bus.read_data_valid_i    = 1'b0;
        bus.read_data_i          = '0;
        bus.read_data_response_i = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.read_address_valid_o) begin
                sub_addr = bus.read_address_o;
                for (int i = 0; i < cfg_ar_wait; i++) begin
                    @(negedge clk);
                    chk("ar_valid_hold", 64'(bus.read_address_valid_o), 64'd1);
                    chk("ar_addr_hold", 64'(bus.read_address_o), 64'(sub_addr));
                    chk("no_rsp_in_addr", 64'(bus.rsp_valid_o), 64'd0);
                end
                bus.read_address_ready_i = 1'b1;
                @(negedge clk);
                bus.read_address_ready_i = 1'b0;
                if (!cfg_r_never) begin
                    repeat (cfg_r_wait) @(negedge clk);
                    bus.read_data_i          = cfg_data;
                    bus.read_data_response_i = cfg_resp;
                    bus.read_data_valid_i    = 1'b1;
                    for (int k = 0; k < 200 && !bus.read_data_ready_o; k++) @(negedge clk);
                    @(negedge clk);
                    bus.read_data_valid_i = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before t=500000");
        $fatal(1, "bench watchdog expired");
    end

    initial begin : main
        int       lat;
        int       last_acc;
        int       h0;
        exp_rsp_t got;

        //          addr         arw rw  r_data        rr    rspw lat exp_data      er    to    tput
        vecs[0] = '{32'h0000_0008, 0, 0, 32'hDEAD_BEEF, 2'b00, 0,  3, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0010,10, 0, 32'hCAFE_0001, 2'b00, 0, 13, 32'hCAFE_0001, 2'b00, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0040, 0, 0, 32'h0BAD_F00D, 2'b10, 0,  3, 32'h0BAD_F00D, 2'b10, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0020, 0, 8, 32'h0000_1234, 2'b00, 0, 10, 32'h0000_0000, 2'b10, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0024, 0, 0, 32'h5555_AAAA, 2'b01, 0,  3, 32'h5555_AAAA, 2'b01, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0028, 0, 7, 32'h7777_0007, 2'b11, 0, 10, 32'h7777_0007, 2'b11, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_002C, 0, 0, 32'h1111_2222, 2'b00, 5,  3, 32'h1111_2222, 2'b00, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0030, 0, 0, 32'hA0A0_0030, 2'b00, 0,  3, 32'hA0A0_0030, 2'b00, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_0034, 0, 0, 32'hA0A0_0034, 2'b00, 0,  3, 32'hA0A0_0034, 2'b00, 1'b0, 1'b1};
        vecs[9] = '{32'h0000_0038, 0, 0, 32'hA0A0_0038, 2'b00, 0,  3, 32'hA0A0_0038, 2'b00, 1'b0, 1'b1};

        rst_n             = 1'b0;
        bus.cmd_valid_i   = 1'b0;
        bus.cmd_address_i = '0;
        bus.rsp_ready_i   = 1'b0;
        last_acc          = 0;
        #1;
        chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
        chk("rst_ar_valid", 64'(bus.read_address_valid_o), 64'd0);
        chk("rst_r_ready", 64'(bus.read_data_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("cmd_ready_before_clk", 64'(bus.cmd_ready_o), 64'd0);
        @(posedge clk); #1;
        chk("cmd_ready_after_release", 64'(bus.cmd_ready_o), 64'd1);
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            cfg_ar_wait = vecs[v].ar_wait;
            cfg_r_wait  = vecs[v].r_wait;
            cfg_data    = vecs[v].r_data;
            cfg_resp    = vecs[v].r_resp;
            cfg_r_never = 1'b0;
            for (int k = 0; k < 50 && !bus.cmd_ready_o; k++) @(negedge clk);
            chk("cmd_ready_idle", 64'(bus.cmd_ready_o), 64'd1);
            bus.cmd_address_i = vecs[v].addr;
            bus.cmd_valid_i   = 1'b1;
            @(negedge clk);
            bus.cmd_valid_i   = 1'b0;
            bus.cmd_address_i = $urandom;
            sb.push_back('{vecs[v].exp_data, vecs[v].exp_resp, vecs[v].exp_to});
            if (vecs[v].chk_tput) chk("accept_interval", 64'(cyc - last_acc), 64'd4);
            last_acc = cyc;
            chk("cmd_ready_low", 64'(bus.cmd_ready_o), 64'd0);
            chk("ar_valid", 64'(bus.read_address_valid_o), 64'd1);
            chk("ar_addr", 64'(bus.read_address_o), 64'(vecs[v].addr));
            chk("busy", 64'(busy), 64'd1);

            lat = 1;
            while (!bus.rsp_valid_o && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            chk("rsp_latency", 64'(lat), 64'(vecs[v].exp_lat));

            for (int i = 0; i < vecs[v].rsp_wait; i++) begin
                @(negedge clk);
                chk("rsp_valid_hold", 64'(bus.rsp_valid_o), 64'd1);
                chk("rsp_data_hold", 64'(bus.rsp_data_o), 64'(vecs[v].exp_data));
                chk("rsp_resp_hold", 64'(bus.rsp_response_o), 64'(vecs[v].exp_resp));
                chk("cmd_ready_in_resp", 64'(bus.cmd_ready_o), 64'd0);
            end

            bus.rsp_ready_i = 1'b1;
            if (sb.size() == 0) begin
                chk("scoreboard_nonempty", 64'd0, 64'd1);
            end else begin
                got = sb.pop_front();
                chk("rsp_data", 64'(bus.rsp_data_o), 64'(got.data));
                chk("rsp_resp", 64'(bus.rsp_response_o), 64'(got.resp));
                chk("rsp_timeout", 64'(bus.rsp_timeout_o), 64'(got.to));
            end
            @(negedge clk);
            bus.rsp_ready_i = 1'b0;
            chk("rsp_valid_clear", 64'(bus.rsp_valid_o), 64'd0);
            chk("cmd_ready_after_rsp", 64'(bus.cmd_ready_o), 64'(!vecs[v].exp_to));

            if (vecs[v].exp_to) begin
                h0 = r_hs;
                for (int k = 0; k < 50; k++) begin
                    if (r_hs != h0) break;
                    chk("cmd_ready_in_drain", 64'(bus.cmd_ready_o), 64'd0);
                    @(negedge clk);
                end
                chk("late_beat_drained", 64'(r_hs), 64'(h0 + 1));
                chk("cmd_ready_after_drain", 64'(bus.cmd_ready_o), 64'd1);
            end
        end

        // Asynchronous reset while waiting in DATA.
        cfg_ar_wait = 0;
        cfg_r_never = 1'b1;
        for (int k = 0; k < 50 && !bus.cmd_ready_o; k++) @(negedge clk);
        bus.cmd_address_i = 32'h0000_0050;
        bus.cmd_valid_i   = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_data_r_ready", 64'(bus.read_data_ready_o), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
        chk("async_r_ready", 64'(bus.read_data_ready_o), 64'd0);
        chk("async_ar_valid", 64'(bus.read_address_valid_o), 64'd0);
        chk("async_ar_addr", 64'(bus.read_address_o), 64'd0);
        chk("async_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("async_rsp_data", 64'(bus.rsp_data_o), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("cmd_ready_before_clk2", 64'(bus.cmd_ready_o), 64'd0);
        @(posedge clk); #1;
        chk("cmd_ready_after_release2", 64'(bus.cmd_ready_o), 64'd1);
        chk("busy_after_release2", 64'(busy), 64'd0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
